// File: rtl/isqrt_shared_arb_if.sv
// isqrt_shared_arb_if: requester bus of isqrt_shared_arb; stats signals exist only with ISQRT_SHARED_ARB_STATS_EN
interface isqrt_shared_arb_if #(parameter int N_REQ = 4);
  logic [N_REQ-1:0] req_vld;
  logic [N_REQ*32-1:0] req_x;
  logic [N_REQ-1:0] req_rdy;
  logic [N_REQ-1:0] rsp_vld;
  logic [31:0] rsp_y;
  logic busy;
`ifdef ISQRT_SHARED_ARB_STATS_EN
  logic [N_REQ*16-1:0] stat_grants;
  logic [15:0] stat_stall;
  modport master(output req_vld, req_x, input req_rdy, rsp_vld, rsp_y, busy, stat_grants, stat_stall);
  modport slave(input req_vld, req_x, output req_rdy, rsp_vld, rsp_y, busy, stat_grants, stat_stall);
`else
  modport master(output req_vld, req_x, input req_rdy, rsp_vld, rsp_y, busy);
  modport slave(input req_vld, req_x, output req_rdy, rsp_vld, rsp_y, busy);
`endif
endinterface

// File: rtl/isqrt_shared_arb.sv
// isqrt_shared_arb: round-robin sharing of one pipelined isqrt between N_REQ requesters; ISQRT_SHARED_ARB_STATS_EN adds grant/stall counters
module isqrt_shared_arb #(
  parameter int N_REQ = 4,
  parameter int ISQRT_STAGES = 4,
  parameter int TAG_DEPTH = 8
) (
  input logic clk,
  input logic rst,
  isqrt_shared_arb_if.slave bus
);
  localparam int IW = $clog2(N_REQ);
  localparam int PW = $clog2(TAG_DEPTH);
  typedef struct packed {
    logic [31:0] x;
    logic [17:0] rem;
    logic [15:0] root;
  } sq_t;
  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n
    $error("N_REQ must be in 2..8");
  end
  if (ISQRT_STAGES < 1 || ISQRT_STAGES > 16) begin : g_bad_s
    $error("ISQRT_STAGES must be in 1..16");
  end
  if (TAG_DEPTH < ISQRT_STAGES + 1 || (TAG_DEPTH & (TAG_DEPTH - 1)) != 0) begin : g_bad_d
    $error("TAG_DEPTH must be a power of 2 and >= isqrt latency + 1");
  end
  function automatic logic [IW-1:0] wrap(input int v);
    return IW'(v % N_REQ);
  endfunction
  function automatic int iters(input int s);
    return 16 * (s + 1) / ISQRT_STAGES - 16 * s / ISQRT_STAGES;
  endfunction
  function automatic sq_t sq_step(input sq_t s, input int n);
    sq_t r;
    logic [19:0] sh, tr;
    r = s;
    for (int i = 0; i < n; i++) begin
      sh = {r.rem, r.x[31:30]};
      tr = {2'b00, r.root, 2'b01};
      r.x = {r.x[29:0], 2'b00};
      r.rem = sh >= tr ? 18'(sh - tr) : sh[17:0];
      r.root = {r.root[14:0], sh >= tr};
    end
    return r;
  endfunction
  logic [IW-1:0] ptr, winner;
  logic any, accept, tag_full, tag_empty, issue_vld, y_vld;
  logic [31:0] issue_x;
  logic [15:0] y;
  sq_t st_q [ISQRT_STAGES];
  logic [ISQRT_STAGES-1:0] v_q;
  logic [IW-1:0] tag_mem [TAG_DEPTH];
  logic [PW:0] wp, rp;
  // Round-robin search: the valid requester closest to ptr (wrapping) wins
  always_comb begin
    winner = ptr;
    any = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (bus.req_vld[wrap(int'(ptr) + k)]) begin
        winner = wrap(int'(ptr) + k);
        any = 1'b1;
      end
  end
  assign accept = any && !tag_full && !rst;
  assign bus.req_rdy = accept ? N_REQ'(1) << winner : '0;
  // Issue register; the operand only changes on acceptance so the datapath stays quiet when idle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ptr <= '0;
      issue_vld <= 1'b0;
      issue_x <= '0;
    end else begin
      issue_vld <= accept;
      if (accept) begin
        ptr <= wrap(int'(winner) + 1);
        issue_x <= bus.req_x[32*winner +: 32];
      end
    end
  assign tag_empty = wp == rp;
  assign tag_full = wp[PW] != rp[PW] && wp[PW-1:0] == rp[PW-1:0];
  // Tag FIFO pointers: push on accept, pop when the matching root leaves the isqrt
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (accept) wp <= wp + 1'b1;
      if (y_vld) rp <= rp + 1'b1;
    end
  // Tag storage needs no reset; only entries between rp and wp are ever read
  always_ff @(posedge clk)
    if (accept) tag_mem[wp[PW-1:0]] <= winner;
  // isqrt datapath: 16 restoring root digits spread evenly over ISQRT_STAGES registers
  always_ff @(posedge clk) begin
    st_q[0] <= sq_step(sq_t'{issue_x, 18'd0, 16'd0}, iters(0));
    for (int s = 1; s < ISQRT_STAGES; s++) st_q[s] <= sq_step(st_q[s-1], iters(s));
  end
  // isqrt valid travels alongside the datapath
  always_ff @(posedge clk or posedge rst)
    if (rst) v_q <= '0;
    else v_q <= ISQRT_STAGES'({v_q, issue_vld});
  assign y_vld = v_q[ISQRT_STAGES-1];
  assign y = st_q[ISQRT_STAGES-1].root;
  // Output register routes each root to the requester whose tag heads the FIFO
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.rsp_vld <= '0;
      bus.rsp_y <= '0;
    end else begin
      bus.rsp_vld <= y_vld ? N_REQ'(1) << tag_mem[rp[PW-1:0]] : '0;
      if (y_vld) bus.rsp_y <= {16'd0, y};
    end
  assign bus.busy = issue_vld || !tag_empty || |bus.rsp_vld;
  // A root arriving with no tag means the pipeline and tag FIFO have diverged
  always_ff @(posedge clk)
    if (!rst) assert (!(y_vld && tag_empty));
`ifdef ISQRT_SHARED_ARB_STATS_EN
  logic [15:0] grants [N_REQ];
  logic [15:0] stall;
  // Saturating accept counters per requester and a saturating stall-cycle counter
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) grants[i] <= '0;
      stall <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++)
        if (bus.req_rdy[i] && grants[i] != 16'hFFFF) grants[i] <= grants[i] + 16'd1;
      if (|bus.req_vld && !accept && stall != 16'hFFFF) stall <= stall + 16'd1;
    end
  // Flatten the grant counters onto the packed stats bus
  always_comb begin
    bus.stat_grants = '0;
    for (int i = 0; i < N_REQ; i++) bus.stat_grants[16*i +: 16] = grants[i];
  end
  assign bus.stat_stall = stall;
`endif
endmodule
